// File: rtl/fetch.sv
// Instruction fetch stage: issues in-order imem reads under a credit limit, buffers
// returned words and feeds the F/D register; decode redirects flush wrong-path work.
module fetch #(
  parameter int              WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            controllchangeD,
  input  logic [WORD-1:0] pcnD,
  output logic            imemReq,
  output logic [WORD-1:0] imemAddr,
  input  logic            imemGnt,
  input  logic            imemRvalid,
  input  logic [WORD-1:0] imemRdata,
  output logic [WORD-1:0] pcD,
  output logic [WORD-1:0] instrD,
  output logic            validD
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD-1:0] NOP  = WORD'(32'h0000_0013);
  localparam logic [WORD-1:0] STEP = WORD'(4);

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
  } entry_t;

  logic [WORD-1:0] fetch_pc;
  logic [WORD-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   buf_cnt;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  entry_t          buf_mem [DEPTH];

  logic          redirect;
  logic [CW:0]   inflight;
  logic          grant;
  logic          rsp;
  logic          rsp_drop;
  logic          rsp_live;
  logic          buf_empty;
  logic          bypass;
  logic          push;
  logic          pop;

  // Credit counts only what is already in flight or buffered this cycle.
  assign redirect  = en & validD & controllchangeD;
  assign inflight  = {1'b0, outstanding} + {1'b0, buf_cnt};
  assign imemReq   = reset & ~redirect & (inflight < (CW+1)'(DEPTH));
  assign imemAddr  = fetch_pc;
  assign grant     = imemReq & imemGnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp       = imemRvalid & (outstanding != '0);
  assign rsp_drop  = rsp & (drop_cnt != '0);
  assign rsp_live  = rsp & (drop_cnt == '0);
  assign buf_empty = (buf_cnt == '0);
  assign bypass    = rsp_live & buf_empty & en & ~redirect;
  assign push      = rsp_live & ~redirect & ~bypass;
  assign pop       = en & ~redirect & ~buf_empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (redirect) begin
        // Every read still in flight belongs to the abandoned path.
        fetch_pc <= pcnD;
        resp_pc  <= pcnD;
        drop_cnt <= outstanding - CW'(rsp);
      end else begin
        if (grant)    fetch_pc <= fetch_pc + STEP;
        if (rsp_live) resp_pc  <= resp_pc + STEP;
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_cnt <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (redirect) begin
      buf_cnt <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
    end
  end

  // NOTE: buffer storage has no reset; buf_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) buf_mem[tail] <= '{pc: resp_pc, instr: imemRdata};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcD    <= '0;
      instrD <= NOP;
      validD <= 1'b0;
    end else if (en) begin
      if (redirect) begin
        validD <= 1'b0;
      end else if (pop) begin
        pcD    <= buf_mem[head].pc;
        instrD <= buf_mem[head].instr;
        validD <= 1'b1;
      end else if (bypass) begin
        pcD    <= resp_pc;
        instrD <= imemRdata;
        validD <= 1'b1;
      end else begin
        validD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: zero-wait in-order memory model with an optional response
// hold, covering streaming, stalls, grant backpressure, redirects and async reset.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        controllchangeD = 1'b0;
  logic [31:0] pcnD = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b1;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = '0;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rq[$];
  bit          rhold = 1'b0;

  fetch #(.WORD(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .en(en), .controllchangeD(controllchangeD), .pcnD(pcnD),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .pcD(pcD), .instrD(instrD), .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Granted reads return in order the cycle after their grant unless held back.
  task automatic tick();
    #1;
    if (imemReq && imemGnt) rq.push_back(imemAddr);
    @(posedge clk);
    #1;
    if (!rhold && rq.size() > 0) begin
      imemRvalid = 1'b1;
      imemRdata  = mem(rq.pop_front());
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = '0;
    end
  endtask

  initial begin
    reset = 1'b0;
    #3;
    check("rst_validD", validD, 0);
    check("rst_req", imemReq, 0);
    check("rst_instrD", instrD, 32'h13);
    check("rst_pcD", pcD, 0);
    #9 reset = 1'b1;
    #1;
    check("start_req", imemReq, 1);
    check("start_addr", imemAddr, 32'h0);

    tick();
    check("lat_valid0", validD, 0);
    check("lat_addr4", imemAddr, 32'h4);
    tick();
    check("first_valid", validD, 1);
    check("first_pc", pcD, 32'h0);
    check("first_instr", instrD, mem(32'h0));
    tick();
    check("pc4", pcD, 32'h4);
    check("instr4", instrD, mem(32'h4));
    rhold = 1'b1;
    tick();
    check("pc8_valid", validD, 1);
    check("pc8", pcD, 32'h8);

    // Redirect while the 0xC response is still outstanding.
    controllchangeD = 1'b1;
    pcnD = 32'h100;
    rhold = 1'b0;
    #1;
    check("redir_withdraw", imemReq, 0);
    tick();
    controllchangeD = 1'b0;
    check("redir_valid0", validD, 0);
    check("redir_addr", imemAddr, 32'h100);
    check("redir_req", imemReq, 1);
    tick();
    check("drop_valid0", validD, 0);
    tick();
    check("tgt_valid", validD, 1);
    check("tgt_pc", pcD, 32'h100);
    check("tgt_instr", instrD, mem(32'h100));
    tick();
    check("tgt_pc104", pcD, 32'h104);

    // Stall decode for four cycles.
    en = 1'b0;
    tick();
    check("stall_req_drop", imemReq, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("stall_pc", pcD, 32'h104);
      check("stall_instr", instrD, mem(32'h104));
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("resume_valid", validD, 1);
      check("resume_pc", pcD, 32'h108 + 32'(4 * i));
      check("resume_instr", instrD, mem(32'h108 + 32'(4 * i)));
    end

    // Grant backpressure.
    check("gnt_addr0", imemAddr, 32'h11C);
    imemGnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gnt_req_hold", imemReq, 1);
      check("gnt_addr_hold", imemAddr, 32'h11C);
    end
    imemGnt = 1'b1;
    tick();
    check("gnt_addr_next", imemAddr, 32'h120);
    tick();
    check("gnt_pc", pcD, 32'h11C);
    check("gnt_valid", validD, 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", validD, 0);
    check("mid_rst_req", imemReq, 0);
    check("mid_rst_instr", instrD, 32'h13);
    rq.delete();
    imemRvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("restart_addr", imemAddr, 32'h0);
    tick();
    check("restart_valid0", validD, 0);
    tick();
    check("restart_pc", pcD, 32'h0);
    check("restart_valid", validD, 1);

    // Redirect request while stalled is ignored until the pipeline advances.
    en = 1'b0;
    controllchangeD = 1'b1;
    pcnD = 32'h200;
    tick();
    check("stallredir_valid", validD, 1);
    check("stallredir_pc", pcD, 32'h0);
    check("stallredir_addr", imemAddr, 32'hC);
    check("stallredir_req", imemReq, 0);
    tick();
    check("stallredir_pc2", pcD, 32'h0);
    en = 1'b1;
    tick();
    controllchangeD = 1'b0;
    check("late_redir_valid0", validD, 0);
    check("late_redir_addr", imemAddr, 32'h200);
    tick();
    check("flush_valid0", validD, 0);
    tick();
    check("late_tgt_valid", validD, 1);
    check("late_tgt_pc", pcD, 32'h200);
    check("late_tgt_instr", instrD, mem(32'h200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
